trng_ctrl: RTL

Sequencing and sharing controller for the dual-base TRNG sampler. It drives the sampler's enable, calibrate and read controls, and holds its handshake levels until the slow divided-clock side acknowledges them. Completed 32-bit words are prefetched into a small FIFO. Two requesters (CPU register port and a secondary consumer) draw from that FIFO under round-robin arbitration. The block sits between the peripheral register interface and the TRNG sampler, in the same clock domain as the sampler's input clock.

---
 rtl/trng_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/trng_ctrl.sv
// trng_ctrl: sequences the dual-base TRNG sampler (calibrate, read, wait),
// buffers finished words in a small FIFO and hands them out to two
// requesters under round-robin arbitration. Every output is a register.
module trng_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 65536
) (
  input  logic                        iClk,
  input  logic                        iRst_n,
  input  logic                        iEn,
  input  logic                        iSel_base,
  input  logic [1:0]                  iReq,
  output logic [1:0]                  oGnt,
  output logic [31:0]                 oData,
  output logic [$clog2(FIFO_DEPTH):0] oLevel,
  output logic                        oError,
  output logic                        oTrng_en,
  output logic                        oTrng_calib,
  output logic                        oTrng_read,
  output logic                        oTrng_sel,
  input  logic                        iTrng_ready,
  input  logic [31:0]                 iTrng_random
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] FULL   = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_OFF, S_CAL, S_IDLE, S_REQ, S_WAIT, S_ERR
  } state_t;

  state_t          state, next_state;
  logic [TW-1:0]   timer;
  logic            timed_out;
  logic            push;
  logic            pop;
  logic            rr_ptr;
  logic [1:0]      elig;
  logic [1:0]      gnt_next;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     mem [FIFO_DEPTH];

  assign timed_out = (timer == T_LAST);

  // Next-state decode: handshake progress, phase timeout, and the iEn override.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    next_state = state;
    push       = 1'b0;
    unique case (state)
      S_OFF:  if (iEn) next_state = S_CAL;
      S_CAL: begin
        if (iTrng_ready)    next_state = S_IDLE;
        else if (timed_out) next_state = S_ERR;
      end
      S_IDLE: if (oLevel < FULL) next_state = S_REQ;
      S_REQ: begin
        if (!iTrng_ready)   next_state = S_WAIT;
        else if (timed_out) next_state = S_ERR;
      end
      S_WAIT: begin
        if (iTrng_ready) begin
          push       = 1'b1;
          next_state = S_IDLE;
        end else if (timed_out) begin
          next_state = S_ERR;
        end
      end
      S_ERR:   next_state = S_ERR;
      default: next_state = S_OFF;
    endcase
    // Dropping the enable wins over everything and discards any arriving word.
    if (!iEn) begin
      next_state = S_OFF;
      push       = 1'b0;
    end
  end

  // State register plus the per-phase timer, which restarts on every state change.
  always_ff @(posedge iClk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!iRst_n) begin
      state <= S_OFF;
      timer <= '0;
    end else begin
      state <= next_state;
      timer <= (next_state != state) ? '0 : timer + 1'b1;
    end
  end

  // Sampler controls and error flag, registered from the state being entered.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      oTrng_en    <= 1'b0;
      oTrng_calib <= 1'b0;
      oTrng_read  <= 1'b0;
      oTrng_sel   <= 1'b0;
      oError      <= 1'b0;
    end else begin
      oTrng_en    <= (next_state != S_OFF) && (next_state != S_ERR);
      oTrng_calib <= (next_state == S_CAL);
      oTrng_read  <= (next_state == S_REQ);
      oError      <= (next_state == S_ERR);
      if ((state == S_OFF) && (next_state == S_CAL)) oTrng_sel <= iSel_base;
    end
  end

  // Round-robin pick; the requester granted last cycle is masked so it can drop iReq.
  always_comb begin
    elig     = iReq & ~oGnt;
    gnt_next = 2'b00;
    if (iEn && (oLevel != '0)) begin
      if (elig[rr_ptr])       gnt_next[rr_ptr]  = 1'b1;
      else if (elig[~rr_ptr]) gnt_next[~rr_ptr] = 1'b1;
    end
    pop = |gnt_next;
  end

  // Word storage; only the pointers and the count need a reset value.
  always_ff @(posedge iClk) begin
    // NOTE: the array is deliberately not reset; level/pointers define validity, and skipping the reset keeps it RAM-mappable.
    if (push) mem[wr_ptr] <= iTrng_random;
  end

  // FIFO pointers, occupancy, grant pulse and granted data.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      oLevel <= '0;
      oGnt   <= 2'b00;
      oData  <= '0;
      rr_ptr <= 1'b0;
    end else if (!iEn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      oLevel <= '0;
      oGnt   <= 2'b00;
    end else begin
      oGnt <= gnt_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        oData  <= mem[rd_ptr];
        rr_ptr <= gnt_next[0];
      end
      unique case ({push, pop})
        2'b10:   oLevel <= oLevel + 1'b1;
        2'b01:   oLevel <= oLevel - 1'b1;
        default: oLevel <= oLevel;
      endcase
    end
  end

endmodule
